ulpb_rx_layer: RTL and testbench
================================

ULPB_RX_LAYER -- requirements
Module: ulpb_rx_layer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of 41-bit entries {addr,data,last}; power of two, 2..16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, flops on RX_REQ/RX_FAIL synchronizers.
REQ-003 SHALL have parameter LAYER_ADDR, default 8'hab, own address for filtering.
REQ-004 Ports (one clock; reset asynchronous, active-high):
  CLK  in  1  layer clock, all state on rising edge
  RESET  in  1  asynchronous active-high reset
  RX_ADDR  in  8  node RX address, stable while RX_REQ high
  RX_DATA  in  32  node RX word, stable while RX_REQ high
  RX_REQ  in  1  node word-available request, bus-clock domain
  RX_PEND  in  1  more words follow in this message
  RX_FAIL  in  1  node reports message aborted
  RX_ACK  out  1  4-phase acknowledge to node
  MSG_ADDR  out  8  head-entry address
  MSG_DATA  out  32  head-entry word
  MSG_LAST  out  1  head entry ends its message
  MSG_VALID  out  1  committed entry available
  MSG_READY  in  1  consumer pops head when MSG_VALID
  ERR_PULSE  out  1  one-cycle error strobe
  ERR_CODE  out  2  01 fail, 10 overflow, 11 filtered; held until next ERR_PULSE
  BUSY  out  1  message in progress (state not IDLE or uncommitted words held)

Function
REQ-005 SHALL synchronize RX_REQ and RX_FAIL through SYNC_STAGES flops (req_s, fail_s); RX_ADDR/RX_DATA/RX_PEND sampled unsynchronized when req_s high.
REQ-006 SHALL implement FSM IDLE, ACK, FAIL_ACK, DROP, DROP_ACK.
REQ-007 IDLE: fail_s high -> FAIL_ACK; else req_s high and count<FIFO_DEPTH -> write entry {RX_ADDR,RX_DATA,~RX_PEND}, -> ACK; fail_s has priority over req_s.
REQ-008 RX_ACK SHALL rise exactly 1 CLK after the cycle req_s is first seen high with space available (SYNC_STAGES+1 CLK after RX_REQ rises).
REQ-009 ACK/DROP_ACK/FAIL_ACK: hold RX_ACK high until the corresponding synchronized input is low, then RX_ACK low and return to IDLE (or DROP from DROP_ACK); each request accepted once.
REQ-010 Entries SHALL become visible (MSG_VALID) only after the last word (RX_PEND=0) of the message is written; commit pointer advances to write pointer at that edge.
REQ-011 FAIL_ACK entry SHALL roll write pointer back to commit pointer, discarding uncommitted words, and pulse ERR_PULSE with ERR_CODE=01.
REQ-012 Full (count==FIFO_DEPTH, count includes uncommitted) with ≥1 committed entry: RX_ACK withheld until a pop frees space; push uses pre-edge count, a same-cycle pop does not allow a push.
REQ-013 Full with zero committed entries: roll back, ERR_PULSE/ERR_CODE=10, enter DROP; DROP acks and discards words until a word with RX_PEND=0 or fail_s, then IDLE.
REQ-014 Pop: MSG_VALID & MSG_READY advances read pointer at the edge; pointers wrap modulo FIFO_DEPTH.
REQ-015 MSG_* outputs SHALL be driven directly from head entry, no extra latency.

Reset
REQ-016 RESET high SHALL asynchronously clear: RX_ACK=0, MSG_VALID=0, ERR_PULSE=0, ERR_CODE=00, BUSY=0, pointers/count=0, synchronizers=0, state=IDLE; mid-message reset discards all words including committed.

Configuration
REQ-017 With ULPB_RX_ADDR_FILTER_EN defined, the first word of a message whose RX_ADDR is neither LAYER_ADDR nor 8'hff SHALL be acked, not stored, ERR_PULSE/ERR_CODE=11, and the message handled as DROP; without it all addresses are accepted and code 11 never occurs.

Structure
REQ-018 FSM state encodings, ERR_CODE values, and broadcast address 8'hff SHALL live in shared package ulpb_rx_pkg.
REQ-019 Synchronizer SHALL be sub-module ulpb_sync (parameter SYNC_STAGES, reset-clear), instantiated twice.

Verification
REQ-020 Single word addr 8'hab data 32'h1234_5678 PEND=0 -> RX_ACK high 3 CLK after RX_REQ; one pop shows same values with MSG_LAST=1.
REQ-021 Three-word message (PEND 1,1,0) -> MSG_VALID stays low until third ack, then three pops in order, MSG_LAST only on third.
REQ-022 Two words then RX_FAIL -> ERR_CODE=01 pulse, MSG_VALID never rises, next message stored at entry 0 equivalent position.
REQ-023 Five-word message, FIFO_DEPTH=4, empty FIFO -> ERR_CODE=10, all five words acked, nothing popped; following 1-word message delivered.
REQ-024 FIFO holds 4 committed words, MSG_READY=0, new RX_REQ -> RX_ACK stays low; MSG_READY=1 one cycle -> RX_ACK rises within SYNC_STAGES+2 CLK.
REQ-025 ULPB_RX_ADDR_FILTER_EN defined, message to 8'hcd -> acked, ERR_CODE=11, not stored; message to 8'hff stored.

Source files
------------

// File: rtl/ulpb_rx_pkg.sv
// Shared definitions for the ULPB receive layer: FSM states, error codes, broadcast address.
package ulpb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACK      = 3'd1,
    ST_FAIL_ACK = 3'd2,
    ST_DROP     = 3'd3,
    ST_DROP_ACK = 3'd4
  } rx_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_FAIL     = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_FILTERED = 2'b11;

  localparam logic [7:0] BCAST_ADDR = 8'hff;
  localparam int         ENTRY_W    = 41;

endpackage

// File: rtl/ulpb_sync.sv
// Multi-flop level synchronizer with asynchronous clear.
module ulpb_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) sync_reg[i] <= sync_reg[i-1];
      sync_reg[0] <= d;
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/ulpb_rx_layer.sv
// ULPB receive layer: 4-phase node handshake into a message-committed FIFO.
// Optional address filtering is enabled by defining ULPB_RX_ADDR_FILTER_EN.
module ulpb_rx_layer
  import ulpb_rx_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] LAYER_ADDR  = 8'hab
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  RX_ADDR,
  input  logic [31:0] RX_DATA,
  input  logic        RX_REQ,
  input  logic        RX_PEND,
  input  logic        RX_FAIL,
  output logic        RX_ACK,
  output logic [7:0]  MSG_ADDR,
  output logic [31:0] MSG_DATA,
  output logic        MSG_LAST,
  output logic        MSG_VALID,
  input  logic        MSG_READY,
  output logic        ERR_PULSE,
  output logic [1:0]  ERR_CODE,
  output logic        BUSY
);

  localparam int             PW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [PW-1:0]  PTR_ONE = PW'(1);
`ifdef ULPB_RX_ADDR_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

  rx_state_t     state_reg;
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, cm_ptr_reg;
  logic [PW-1:0] rd_ptr_next, wr_ptr_next, cm_ptr_next;
  logic [CW-1:0] count_reg, ccount_reg, count_next, ccount_next, pop_dec;
  logic          ack_reg, err_pulse_reg, drop_end_reg;
  logic [1:0]    err_code_reg;
  logic          req_s, fail_s;
  logic          pop, first_word, addr_ok, addr_reject, has_space;
  logic          push, commit, overflow, rollback;

  ulpb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_req (
    .clk(CLK), .rst(RESET), .d(RX_REQ), .q(req_s)
  );
  ulpb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fail (
    .clk(CLK), .rst(RESET), .d(RX_FAIL), .q(fail_s)
  );

  // count includes uncommitted words; ccount only those visible to the consumer
  always_comb begin
    pop         = (ccount_reg != '0) && MSG_READY;
    pop_dec     = pop ? CNT_ONE : '0;
    first_word  = (count_reg == ccount_reg);
    addr_ok     = (RX_ADDR == LAYER_ADDR) || (RX_ADDR == BCAST_ADDR);
    addr_reject = FILTER_EN && first_word && !addr_ok;
    has_space   = (count_reg < DEPTH_C);
    push        = (state_reg == ST_IDLE) && !fail_s && req_s && !addr_reject && has_space;
    commit      = push && !RX_PEND;
    overflow    = (state_reg == ST_IDLE) && !fail_s && req_s && !addr_reject &&
                  !has_space && (ccount_reg == '0);
    rollback    = ((state_reg == ST_IDLE) && fail_s) || overflow;

    rd_ptr_next = pop ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    cm_ptr_next = commit ? wr_ptr_reg + PTR_ONE : cm_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg - pop_dec;
    if (rollback) begin
      wr_ptr_next = cm_ptr_reg;
      count_next  = ccount_reg - pop_dec;
    end else if (push) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
      count_next  = count_reg + CNT_ONE - pop_dec;
    end
    ccount_next = (commit ? count_reg + CNT_ONE : ccount_reg) - pop_dec;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= {RX_ADDR, RX_DATA, ~RX_PEND};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= ST_IDLE;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      cm_ptr_reg    <= '0;
      count_reg     <= '0;
      ccount_reg    <= '0;
      ack_reg       <= 1'b0;
      err_pulse_reg <= 1'b0;
      err_code_reg  <= ERR_NONE;
      drop_end_reg  <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      cm_ptr_reg    <= cm_ptr_next;
      count_reg     <= count_next;
      ccount_reg    <= ccount_next;
      err_pulse_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fail_s) begin
            ack_reg       <= 1'b1;
            err_pulse_reg <= 1'b1;
            err_code_reg  <= ERR_FAIL;
            state_reg     <= ST_FAIL_ACK;
          end else if (req_s) begin
            if (addr_reject) begin
              ack_reg       <= 1'b1;
              err_pulse_reg <= 1'b1;
              err_code_reg  <= ERR_FILTERED;
              drop_end_reg  <= ~RX_PEND;
              state_reg     <= ST_DROP_ACK;
            end else if (has_space) begin
              ack_reg   <= 1'b1;
              state_reg <= ST_ACK;
            end else if (overflow) begin
              // the word that hit the wall is acked from DROP on the next cycle
              err_pulse_reg <= 1'b1;
              err_code_reg  <= ERR_OVERFLOW;
              state_reg     <= ST_DROP;
            end
          end
        end
        ST_ACK: begin
          if (!req_s) begin
            ack_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_FAIL_ACK: begin
          if (!fail_s) begin
            ack_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        ST_DROP: begin
          if (fail_s) begin
            ack_reg   <= 1'b1;
            state_reg <= ST_FAIL_ACK;
          end else if (req_s) begin
            ack_reg      <= 1'b1;
            drop_end_reg <= ~RX_PEND;
            state_reg    <= ST_DROP_ACK;
          end
        end
        ST_DROP_ACK: begin
          if (!req_s) begin
            ack_reg   <= 1'b0;
            state_reg <= drop_end_reg ? ST_IDLE : ST_DROP;
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign RX_ACK    = ack_reg;
  assign ERR_PULSE = err_pulse_reg;
  assign ERR_CODE  = err_code_reg;
  assign MSG_VALID = (ccount_reg != '0);
  assign MSG_ADDR  = mem[rd_ptr_reg][40:33];
  assign MSG_DATA  = mem[rd_ptr_reg][32:1];
  assign MSG_LAST  = mem[rd_ptr_reg][0];
  assign BUSY      = (state_reg != ST_IDLE) || (count_reg != ccount_reg);

endmodule

// File: tb/tb_ulpb_rx_layer.sv
// Directed self-checking bench for ulpb_rx_layer (default FIFO_DEPTH=4, SYNC_STAGES=2).
module tb_ulpb_rx_layer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  RX_ADDR = '0;
  logic [31:0] RX_DATA = '0;
  logic        RX_REQ = 1'b0;
  logic        RX_PEND = 1'b0;
  logic        RX_FAIL = 1'b0;
  logic        RX_ACK;
  logic [7:0]  MSG_ADDR;
  logic [31:0] MSG_DATA;
  logic        MSG_LAST;
  logic        MSG_VALID;
  logic        MSG_READY = 1'b0;
  logic        ERR_PULSE;
  logic [1:0]  ERR_CODE;
  logic        BUSY;

  int checks = 0;
  int fails = 0;
  int err_count = 0;
  logic [1:0] err_last = 2'b00;

  ulpb_rx_layer dut (
    .CLK(CLK), .RESET(RESET), .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA),
    .RX_REQ(RX_REQ), .RX_PEND(RX_PEND), .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK),
    .MSG_ADDR(MSG_ADDR), .MSG_DATA(MSG_DATA), .MSG_LAST(MSG_LAST),
    .MSG_VALID(MSG_VALID), .MSG_READY(MSG_READY), .ERR_PULSE(ERR_PULSE),
    .ERR_CODE(ERR_CODE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (ERR_PULSE === 1'b1) begin
      err_count++;
      err_last = ERR_CODE;
    end
  end

  // Node-side 4-phase transfer of one word; each wait is bounded.
  task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic p);
    int n;
    @(negedge CLK);
    RX_ADDR = a; RX_DATA = d; RX_PEND = p; RX_REQ = 1'b1;
    n = 0;
    while (RX_ACK !== 1'b1 && n < 30) begin @(negedge CLK); n++; end
    checks++;
    if (RX_ACK !== 1'b1) begin
      fails++;
      $display("FAIL send_ack_rise: RX_ACK=%b required 1 (addr %h data %h)", RX_ACK, a, d);
    end
    RX_REQ = 1'b0;
    n = 0;
    while (RX_ACK !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
    checks++;
    if (RX_ACK !== 1'b0) begin
      fails++;
      $display("FAIL send_ack_fall: RX_ACK=%b required 0 (addr %h data %h)", RX_ACK, a, d);
    end
    $display("word addr=%h data=%h pend=%0b transferred", a, d, p);
  endtask

  task automatic do_pop();
    MSG_READY = 1'b1;
    @(negedge CLK);
    MSG_READY = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({RX_ACK, MSG_VALID, ERR_PULSE, ERR_CODE, BUSY} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: ack/valid/pulse/code/busy=%b required 000000",
               {RX_ACK, MSG_VALID, ERR_PULSE, ERR_CODE, BUSY});
    end
    RESET = 1'b0;
    @(negedge CLK);
    $display("reset released");
  endtask

  task automatic test_single();
    int n;
    @(negedge CLK);
    RX_ADDR = 8'hab; RX_DATA = 32'h1234_5678; RX_PEND = 1'b0; RX_REQ = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (RX_ACK !== 1'b0) begin
      fails++; $display("FAIL single_ack_early: RX_ACK=%b required 0 after 2 clocks", RX_ACK);
    end
    @(negedge CLK);
    checks++;
    if (RX_ACK !== 1'b1) begin
      fails++; $display("FAIL single_ack_latency: RX_ACK=%b required 1 after 3 clocks", RX_ACK);
    end
    checks++;
    if (BUSY !== 1'b1 || MSG_VALID !== 1'b1) begin
      fails++; $display("FAIL single_busy_valid: busy=%b valid=%b required 1 1", BUSY, MSG_VALID);
    end
    RX_REQ = 1'b0;
    n = 0;
    while (RX_ACK !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
    checks++;
    if ({MSG_ADDR, MSG_DATA, MSG_LAST} !== {8'hab, 32'h1234_5678, 1'b1}) begin
      fails++;
      $display("FAIL single_head: got %h %h %b required ab 12345678 1", MSG_ADDR, MSG_DATA, MSG_LAST);
    end
    do_pop();
    checks++;
    if (MSG_VALID !== 1'b0) begin
      fails++; $display("FAIL single_pop_empty: MSG_VALID=%b required 0", MSG_VALID);
    end
    $display("single word message popped");
  endtask

  task automatic test_multi();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h1111_1111; exp_d[1] = 32'h2222_2222; exp_d[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      send_word(8'hab, exp_d[i], (i < 2) ? 1'b1 : 1'b0);
      checks++;
      if (MSG_VALID !== ((i == 2) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL multi_valid_w%0d: MSG_VALID=%b required %0d", i, MSG_VALID, i == 2);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (MSG_VALID !== 1'b1 || MSG_DATA !== exp_d[i] || MSG_LAST !== ((i == 2) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL multi_pop%0d: valid=%b data=%h last=%b required 1 %h %0d",
                 i, MSG_VALID, MSG_DATA, MSG_LAST, exp_d[i], i == 2);
      end
      do_pop();
    end
    $display("three word message popped");
  endtask

  task automatic test_fail();
    int n;
    send_word(8'hab, 32'h2121_2121, 1'b1);
    send_word(8'hab, 32'h2222_2222, 1'b1);
    @(negedge CLK);
    RX_FAIL = 1'b1;
    n = 0;
    while (RX_ACK !== 1'b1 && n < 30) begin @(negedge CLK); n++; end
    checks++;
    if (RX_ACK !== 1'b1 || ERR_PULSE !== 1'b1 || ERR_CODE !== 2'b01) begin
      fails++;
      $display("FAIL fail_ack_err: ack=%b pulse=%b code=%b required 1 1 01", RX_ACK, ERR_PULSE, ERR_CODE);
    end
    RX_FAIL = 1'b0;
    n = 0;
    while (RX_ACK !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
    checks++;
    if (MSG_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++; $display("FAIL fail_discard: valid=%b busy=%b required 0 0", MSG_VALID, BUSY);
    end
    send_word(8'hab, 32'h3333_0001, 1'b0);
    checks++;
    if (MSG_VALID !== 1'b1 || MSG_DATA !== 32'h3333_0001 || MSG_LAST !== 1'b1) begin
      fails++;
      $display("FAIL fail_next_msg: valid=%b data=%h last=%b required 1 33330001 1", MSG_VALID, MSG_DATA, MSG_LAST);
    end
    do_pop();
    $display("aborted message discarded");
  endtask

  task automatic test_overflow();
    int base;
    checks++;
    if (ERR_CODE !== 2'b01) begin
      fails++; $display("FAIL err_code_held: ERR_CODE=%b required 01", ERR_CODE);
    end
    base = err_count;
    for (int i = 0; i < 5; i++) send_word(8'hab, 32'h5000_0000 + i, (i < 4) ? 1'b1 : 1'b0);
    checks++;
    if (err_count !== base + 1 || err_last !== 2'b10) begin
      fails++; $display("FAIL overflow_err: pulses=%0d code=%b required %0d 10", err_count, err_last, base + 1);
    end
    checks++;
    if (MSG_VALID !== 1'b0 || BUSY !== 1'b0) begin
      fails++; $display("FAIL overflow_empty: valid=%b busy=%b required 0 0", MSG_VALID, BUSY);
    end
    send_word(8'hab, 32'h6000_0006, 1'b0);
    checks++;
    if (MSG_VALID !== 1'b1 || MSG_DATA !== 32'h6000_0006) begin
      fails++; $display("FAIL overflow_next_msg: valid=%b data=%h required 1 60000006", MSG_VALID, MSG_DATA);
    end
    do_pop();
    $display("oversized message dropped");
  endtask

  task automatic test_backpressure();
    int n;
    logic ack_seen;
    for (int i = 0; i < 4; i++) send_word(8'hab, 32'h4100_0000 + i, 1'b0);
    @(negedge CLK);
    RX_ADDR = 8'hab; RX_DATA = 32'h4100_0004; RX_PEND = 1'b0; RX_REQ = 1'b1;
    ack_seen = 1'b0;
    repeat (10) begin @(negedge CLK); if (RX_ACK !== 1'b0) ack_seen = 1'b1; end
    checks++;
    if (ack_seen !== 1'b0) begin
      fails++; $display("FAIL full_ack_withheld: RX_ACK rose=%b required 0", ack_seen);
    end
    checks++;
    if (MSG_VALID !== 1'b1 || MSG_DATA !== 32'h4100_0000) begin
      fails++; $display("FAIL full_head: valid=%b data=%h required 1 41000000", MSG_VALID, MSG_DATA);
    end
    do_pop();
    n = 1;
    while (RX_ACK !== 1'b1 && n < 4) begin @(negedge CLK); n++; end
    checks++;
    if (RX_ACK !== 1'b1) begin
      fails++; $display("FAIL full_ack_after_pop: RX_ACK=%b required 1 within 4 clocks", RX_ACK);
    end
    RX_REQ = 1'b0;
    n = 0;
    while (RX_ACK !== 1'b0 && n < 30) begin @(negedge CLK); n++; end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (MSG_VALID !== 1'b1 || MSG_DATA !== 32'h4100_0000 + i) begin
        fails++;
        $display("FAIL full_drain%0d: valid=%b data=%h required 1 %h", i, MSG_VALID, MSG_DATA, 32'h4100_0000 + i);
      end
      do_pop();
    end
    $display("backpressured word accepted after pop");
  endtask

  task automatic test_reset_mid();
    send_word(8'hab, 32'h5151_5151, 1'b0);
    send_word(8'hab, 32'h5252_5252, 1'b1);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({MSG_VALID, BUSY, ERR_CODE, RX_ACK} !== 5'b0) begin
      fails++;
      $display("FAIL reset_mid: valid/busy/code/ack=%b required 00000", {MSG_VALID, BUSY, ERR_CODE, RX_ACK});
    end
    @(negedge CLK);
    RESET = 1'b0;
    send_word(8'hab, 32'h5353_5353, 1'b0);
    checks++;
    if (MSG_VALID !== 1'b1 || MSG_DATA !== 32'h5353_5353) begin
      fails++; $display("FAIL reset_mid_next: valid=%b data=%h required 1 53535353", MSG_VALID, MSG_DATA);
    end
    do_pop();
    $display("mid-message reset cleared FIFO");
  endtask

`ifdef ULPB_RX_ADDR_FILTER_EN
  task automatic test_filter();
    int base;
    base = err_count;
    send_word(8'hcd, 32'hcdcd_cdcd, 1'b0);
    checks++;
    if (err_count !== base + 1 || err_last !== 2'b11 || MSG_VALID !== 1'b0) begin
      fails++;
      $display("FAIL filter_reject: pulses=%0d code=%b valid=%b required %0d 11 0", err_count, err_last, MSG_VALID, base + 1);
    end
    send_word(8'hff, 32'hffff_0001, 1'b0);
    checks++;
    if (MSG_VALID !== 1'b1 || MSG_ADDR !== 8'hff || MSG_DATA !== 32'hffff_0001) begin
      fails++; $display("FAIL filter_bcast: valid=%b addr=%h data=%h required 1 ff ffff0001", MSG_VALID, MSG_ADDR, MSG_DATA);
    end
    do_pop();
    $display("address filter checked");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_fail();
    test_overflow();
    test_backpressure();
    test_reset_mid();
`ifdef ULPB_RX_ADDR_FILTER_EN
    test_filter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
